// File: rtl/wash_sequencer.sv
// Washing-program sequencer: Fill -> (Wash -> Rinse) x N -> Spin with internally timed phases.
// Supports pause/resume and exposes a remaining-cycle timer and a zero-based pass index.
module wash_sequencer #(
    parameter int CNT_W     = 16,
    parameter int REP_W     = 2,
    parameter int FILL_CYC  = 8,
    parameter int WASH_CYC  = 16,
    parameter int RINSE_CYC = 12,
    parameter int SPIN_CYC  = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Coin,
    input  logic [REP_W-1:0] Wash_Count,
    input  logic             Pause,
    output logic [2:0]       current_state,
    output logic             Wash_Done,
    output logic [REP_W-1:0] Pass_Index,
    output logic [CNT_W-1:0] Timer,
    output logic             Paused
);

    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] FILL  = 3'b001;
    localparam logic [2:0] WASH  = 3'b010;
    localparam logic [2:0] RINSE = 3'b011;
    localparam logic [2:0] SPIN  = 3'b100;

    // Reload values are length-1 so that each phase lasts exactly its length.
    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
    localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYC - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC - 1);
    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);
    localparam logic [REP_W-1:0] P_ONE    = REP_W'(1);
    localparam logic [REP_W:0]   P_ONE_X  = (REP_W+1)'(1);

    logic [REP_W-1:0] pass_total;

    logic [2:0]       state_n;
    logic [CNT_W-1:0] timer_n;
    logic [REP_W-1:0] pass_n;
    logic [REP_W-1:0] total_n;
    logic             done_n;
    logic             expired;
    logic             advance;
    logic             more_passes;

    assign expired     = (Timer == '0);
    assign advance     = !Pause && expired;
    // Widened by one bit so the pass compare cannot wrap at the top count.
    assign more_passes = (({1'b0, Pass_Index} + P_ONE_X) < {1'b0, pass_total});
    assign Paused      = Pause && (current_state != IDLE);

    always_comb begin
        state_n = current_state;
        timer_n = Timer;
        pass_n  = Pass_Index;
        total_n = pass_total;
        done_n  = Wash_Done;
        case (current_state)
            IDLE: begin
                if (Coin) begin
                    state_n = FILL;
                    timer_n = FILL_LD;
                    pass_n  = '0;
                    done_n  = 1'b0;
                    total_n = (Wash_Count == '0) ? P_ONE : Wash_Count;
                end
            end
            FILL, WASH, RINSE, SPIN: begin
                if (!Pause && !expired) begin
                    timer_n = Timer - T_ONE;
                end else if (advance) begin
                    case (current_state)
                        FILL: begin
                            state_n = WASH;
                            timer_n = WASH_LD;
                        end
                        WASH: begin
                            state_n = RINSE;
                            timer_n = RINSE_LD;
                        end
                        RINSE: begin
                            if (more_passes) begin
                                state_n = WASH;
                                timer_n = WASH_LD;
                                pass_n  = Pass_Index + P_ONE;
                            end else begin
                                state_n = SPIN;
                                timer_n = SPIN_LD;
                            end
                        end
                        default: begin
                            state_n = IDLE;
                            timer_n = '0;
                            done_n  = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                pass_n  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            current_state <= IDLE;
            Timer         <= '0;
            Pass_Index    <= '0;
            Wash_Done     <= 1'b0;
            pass_total    <= P_ONE;
        end else begin
            current_state <= state_n;
            Timer         <= timer_n;
            Pass_Index    <= pass_n;
            Wash_Done     <= done_n;
            pass_total    <= total_n;
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: directed program runs with literal run lengths,
// then randomized coin/pause/reset traffic checked every cycle against a phase-level model.
module tb_wash_sequencer;

    localparam int CNT_W = 16;
    localparam int REP_W = 2;
    localparam int FILL_CYC = 8, WASH_CYC = 16, RINSE_CYC = 12, SPIN_CYC = 10;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             Coin = 1'b0;
    logic [REP_W-1:0] Wash_Count = '0;
    logic             Pause = 1'b0;
    logic [2:0]       current_state;
    logic             Wash_Done;
    logic [REP_W-1:0] Pass_Index;
    logic [CNT_W-1:0] Timer;
    logic             Paused;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase number, cycles left in the phase (including the current one), pass info.
    int m_phase = 0, m_rem = 0, m_pass = 0, m_total = 1, m_done = 0;

    wash_sequencer #(
        .CNT_W(CNT_W), .REP_W(REP_W), .FILL_CYC(FILL_CYC), .WASH_CYC(WASH_CYC),
        .RINSE_CYC(RINSE_CYC), .SPIN_CYC(SPIN_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .Coin(Coin), .Wash_Count(Wash_Count), .Pause(Pause),
        .current_state(current_state), .Wash_Done(Wash_Done), .Pass_Index(Pass_Index),
        .Timer(Timer), .Paused(Paused)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phase_len(input int ph);
        case (ph)
            1: return FILL_CYC;
            2: return WASH_CYC;
            3: return RINSE_CYC;
            default: return SPIN_CYC;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_pass = 0; m_total = 1; m_done = 0;
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            if (Coin) begin
                m_phase = 1; m_rem = FILL_CYC; m_pass = 0; m_done = 0;
                m_total = (Wash_Count == 0) ? 1 : int'(Wash_Count);
            end
        end else if (!Pause) begin
            if (m_rem > 1) m_rem--;
            else if (m_phase == 3 && m_pass + 1 < m_total) begin
                m_phase = 2; m_pass++; m_rem = WASH_CYC;
            end else if (m_phase == 4) begin
                m_phase = 0; m_rem = 0; m_done = 1;
            end else begin
                m_phase++; m_rem = phase_len(m_phase);
            end
        end
    endtask

    task automatic compare_all();
        chk("state",  32'(current_state), 32'(m_phase));
        chk("timer",  32'(Timer), (m_phase == 0) ? 32'd0 : 32'(m_rem - 1));
        chk("pass",   32'(Pass_Index), 32'(m_pass));
        chk("done",   32'(Wash_Done), 32'(m_done));
        chk("paused", 32'(Paused), 32'(Pause && m_phase != 0));
    endtask

    // One clock: model consumes the same inputs the DUT samples, then outputs are compared.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    // Called at posedge+1: asserts RST between edges and checks reset values before any edge.
    task automatic async_reset();
        #3 RST = 1'b1;
        #1;
        model_reset();
        chk("rst_state", 32'(current_state), 32'd0);
        chk("rst_timer", 32'(Timer), 32'd0);
        chk("rst_pass",  32'(Pass_Index), 32'd0);
        chk("rst_done",  32'(Wash_Done), 32'd0);
        chk("rst_paused", 32'(Paused), 32'd0);
        #2 RST = 1'b0;
    endtask

    // mode 0: plain; 1: pause 5 cycles mid-WASH and 3 cycles at RINSE timer 0; 2: coin spam in FILL/SPIN
    task automatic run_program(input int wc, input int mode, output int len);
        int p1 = 0, p2 = 0;
        Coin = 1'b1; Wash_Count = REP_W'(wc);
        tick();
        Coin = 1'b0;
        chk("coin_fill", 32'(current_state), 32'd1);
        chk("coin_clears_done", 32'(Wash_Done), 32'd0);
        len = 0;
        while (current_state != 3'd0 && len < 1000) begin
            Pause = 1'b0; Coin = 1'b0;
            if (mode == 1) begin
                if (current_state == 3'd2 && Timer <= 10 && p1 < 5) begin Pause = 1'b1; p1++; end
                else if (current_state == 3'd3 && Timer == 0 && p2 < 3) begin Pause = 1'b1; p2++; end
            end else if (mode == 2) begin
                if ((current_state == 3'd1 || current_state == 3'd4) && Timer[0]) begin
                    Coin = 1'b1; Wash_Count = 2'd3;
                end
            end
            tick();
            len++;
        end
        Pause = 1'b0; Coin = 1'b0;
        chk("run_done_flag", 32'(Wash_Done), 32'd1);
    endtask

    initial begin
        int len;
        int guard;
        #7;
        chk("init_state", 32'(current_state), 32'd0);
        chk("init_timer", 32'(Timer), 32'd0);
        chk("init_done", 32'(Wash_Done), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        Pause = 1'b1;
        tick();
        chk("idle_pause_paused", 32'(Paused), 32'd0);
        Pause = 1'b0;

        run_program(1, 0, len); chk("len_single", 32'(len), 32'd46);
        run_program(2, 0, len); chk("len_double", 32'(len), 32'd74);
        run_program(0, 0, len); chk("len_zero",   32'(len), 32'd46);
        run_program(1, 1, len); chk("len_pause",  32'(len), 32'd54);
        run_program(1, 2, len); chk("len_coin_spam", 32'(len), 32'd46);
        run_program(3, 0, len); chk("len_triple", 32'(len), 32'd102);

        // Reset a few cycles into RINSE of pass 1.
        Coin = 1'b1; Wash_Count = 2'd2;
        tick();
        Coin = 1'b0;
        guard = 0;
        while (!(current_state == 3'd3 && Pass_Index == 2'd1 && Timer == 16'd8) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_rinse_p1", 32'(guard < 200), 32'd1);
        Pause = 1'b1;
        async_reset();
        Pause = 1'b0;
        tick();
        run_program(1, 0, len); chk("len_after_reset", 32'(len), 32'd46);

        for (int i = 0; i < 4000; i++) begin
            Coin       = ($urandom_range(0, 15) == 0);
            Wash_Count = REP_W'($urandom);
            Pause      = ($urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
